// File: rtl/maze_path_loader.sv
// Maze path loader: parses a header/rows/checksum byte stream into the 64x64
// path bitmap, maze dimensions and start tile consumed by the VGA maze renderer.
module maze_path_loader (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic [4095:0] path_data,
    output logic [6:0]    maze_width,
    output logic [6:0]    maze_height,
    output logic [6:0]    char_x,
    output logic [6:0]    char_y,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          render_enable,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_ROWS   = 3'd2,
        S_CHECK  = 3'd3,
        S_OK     = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t      state, state_next;
    logic [1:0]  hdr_cnt;
    logic [2:0]  byte_idx;
    logic [5:0]  row_idx;
    logic [7:0]  xsum;
    logic        xfer;
    logic        hdr_bad;
    logic        chk_bad;
    logic [6:0]  width_m1;
    logic [2:0]  last_byte;
    logic        last_row;
    logic        start_tile;

    // Handshake: a byte moves on any rising edge where in_valid && in_ready;
    // in_ready depends only on state, never on in_valid.
    assign xfer       = in_valid && in_ready;
    assign width_m1   = maze_width - 7'd1;
    assign last_byte  = width_m1[5:3];
    assign last_row   = ({1'b0, row_idx} == (maze_height - 7'd1));
    assign start_tile = path_data[{char_y[5:0], char_x[5:0]}];
    assign chk_bad    = (in_data != xsum) || !start_tile;

    always_comb begin
        hdr_bad = 1'b0;
        case (hdr_cnt)
            2'd0: hdr_bad = (in_data == 8'd0) || (in_data > 8'd64);
            2'd1: hdr_bad = (in_data == 8'd0) || (in_data > 8'd64);
            2'd2: hdr_bad = (in_data >= {1'b0, maze_width});
            default: hdr_bad = (in_data >= {1'b0, maze_height});
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_HEADER;
            end
            S_HEADER: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) begin
                    if (hdr_bad)              state_next = S_FAIL;
                    else if (hdr_cnt == 2'd3) state_next = S_ROWS;
                end
            end
            S_ROWS: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer && byte_idx == last_byte && last_row) state_next = S_CHECK;
            end
            S_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) state_next = chk_bad ? S_FAIL : S_OK;
            end
            S_OK: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            S_FAIL: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr_cnt       <= 2'd0;
            byte_idx      <= 3'd0;
            row_idx       <= 6'd0;
            xsum          <= 8'd0;
            maze_width    <= 7'd0;
            maze_height   <= 7'd0;
            char_x        <= 7'd0;
            char_y        <= 7'd0;
            error         <= 1'b0;
            render_enable <= 1'b0;
        end else if (state == S_IDLE && start) begin
            hdr_cnt       <= 2'd0;
            byte_idx      <= 3'd0;
            row_idx       <= 6'd0;
            xsum          <= 8'd0;
            error         <= 1'b0;
            render_enable <= 1'b0;
        end else if (xfer) begin
            xsum <= xsum ^ in_data;
            case (state)
                S_HEADER: begin
                    hdr_cnt <= hdr_cnt + 2'd1;
                    if (hdr_bad) begin
                        error <= 1'b1;
                    end else begin
                        case (hdr_cnt)
                            2'd0:    maze_width  <= in_data[6:0];
                            2'd1:    maze_height <= in_data[6:0];
                            2'd2:    char_x      <= in_data[6:0];
                            default: char_y      <= in_data[6:0];
                        endcase
                    end
                end
                S_ROWS: begin
                    if (byte_idx == last_byte) begin
                        byte_idx <= 3'd0;
                        row_idx  <= row_idx + 6'd1;
                    end else begin
                        byte_idx <= byte_idx + 3'd1;
                    end
                end
                S_CHECK: begin
                    if (chk_bad) error <= 1'b1;
                    else         render_enable <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Bits at x >= width are written as 0 so a row never leaks stray pixels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            path_data <= '0;
        end else if (state == S_IDLE && start) begin
            path_data <= '0;
        end else if (state == S_ROWS && xfer) begin
            for (int b = 0; b < 8; b++) begin
                path_data[{row_idx, byte_idx, 3'(b)}] <=
                    in_data[b] & ({1'b0, byte_idx, 3'(b)} < maze_width);
            end
        end
    end

endmodule

// File: tb/tb_maze_path_loader.sv
// Bench for maze_path_loader: directed table of streams, hand-written corner
// sequences and random loads checked against a stream-level reference model.
module tb_maze_path_loader;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [4095:0] path_data;
    logic [6:0]    maze_width, maze_height, char_x, char_y;
    logic          busy, done, error, render_enable;
    logic [2:0]    state_dbg;

    maze_path_loader dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .path_data(path_data),
        .maze_width(maze_width), .maze_height(maze_height),
        .char_x(char_x), .char_y(char_y), .busy(busy), .done(done),
        .error(error), .render_enable(render_enable), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset / monitors ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int done_cnt = 0;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  stream_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_path(input string name, input logic [4095:0] exp);
        int nbad;
        int first;
        nbad  = 0;
        first = -1;
        for (int i = 0; i < 4096; i++) begin
            if (path_data[i] !== exp[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL %s: %0d bits differ, first at bit %0d (got %b expected %b)",
                     name, nbad, first, path_data[first], exp[first]);
        end
    endtask

    // ---------------- reference model ----------------
    logic [4095:0] m_path;
    logic          m_err, m_re;
    logic [6:0]    m_w = 0, m_h = 0, m_cx = 0, m_cy = 0;
    int            m_nacc;

    task automatic model_load();
        int w, h, sx, sy, bcnt, x;
        logic [7:0] bt, cs;
        m_path = '0;
        m_err  = 1'b1;
        m_re   = 1'b0;
        w = int'(stream_q[0]);
        if (w < 1 || w > 64) m_nacc = 1;
        else begin
            m_w = 7'(w);
            h = int'(stream_q[1]);
            if (h < 1 || h > 64) m_nacc = 2;
            else begin
                m_h = 7'(h);
                sx = int'(stream_q[2]);
                if (sx >= w) m_nacc = 3;
                else begin
                    m_cx = 7'(sx);
                    sy = int'(stream_q[3]);
                    if (sy >= h) m_nacc = 4;
                    else begin
                        m_cy = 7'(sy);
                        bcnt = (w + 7) / 8;
                        for (int r = 0; r < h; r++)
                            for (int k = 0; k < bcnt; k++) begin
                                bt = stream_q[4 + r * bcnt + k];
                                for (int b = 0; b < 8; b++) begin
                                    x = 8 * k + b;
                                    if (x < w) m_path[x + 64 * r] = bt[b];
                                end
                            end
                        m_nacc = 5 + h * bcnt;
                        cs = 8'd0;
                        for (int i = 0; i < m_nacc - 1; i++) cs ^= stream_q[i];
                        m_err = (stream_q[m_nacc - 1] != cs) || (m_path[sx + 64 * sy] == 1'b0);
                        m_re  = !m_err;
                    end
                end
            end
        end
        exp_q.push_back({2'b00, m_err, m_re, m_w, m_h, m_cx, m_cy});
    endtask

    // ---------------- driver ----------------
    int n_acc, lat;

    task automatic run_load(input bit gaps, input bit mid_start);
        int  budget, idx, s_cyc, d0;
        bit  xfer;
        d0       = done_cnt;
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        s_cyc  = cyc;
        idx    = 0;
        budget = 3000;
        while (busy === 1'b1 && budget > 0) begin
            budget--;
            if ((gaps && (cyc % 2 == 0)) || idx >= stream_q.size()) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = stream_q[idx];
            end
            start = mid_start && (idx == 5);
            xfer  = (in_valid && in_ready === 1'b1);
            @(posedge clk); #1;
            if (xfer) idx++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        n_acc    = idx;
        lat      = cyc - s_cyc;
        if (budget == 0) check("load_timeout", 1, 0);
        check("done_in_end_cycle", done, 1);
        check("ready_in_end_cycle", in_ready, 0);
        check("busy_in_end_cycle", busy, 0);
        @(posedge clk); #1;
        check("done_falls", done, 0);
        check("one_done_pulse", done_cnt - d0, 1);
    endtask

    task automatic check_vs_model(input string name);
        logic [31:0] res;
        res = exp_q.pop_front();
        check({name, "_result"}, {2'b00, error, render_enable, maze_width, maze_height, char_x, char_y}, res);
        check({name, "_accepted"}, n_acc, m_nacc);
        check_path({name, "_path"}, m_path);
    endtask

    task automatic gen_load(input bit big);
        int w, h, sx, sy, bcnt, sel, pos;
        logic [7:0] tmp, x;
        stream_q.delete();
        sel = big ? 9 : $urandom_range(0, 9);
        w  = big ? 64 : $urandom_range(1, 64);
        h  = big ? 64 : $urandom_range(1, 10);
        sx = $urandom_range(0, w - 1);
        sy = $urandom_range(0, h - 1);
        if (sel == 0) w  = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(65, 255);
        if (sel == 1) h  = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(65, 255);
        if (sel == 2) sx = $urandom_range(w, 255);
        if (sel == 3) sy = $urandom_range(h, 255);
        stream_q.push_back(8'(w));
        stream_q.push_back(8'(h));
        stream_q.push_back(8'(sx));
        stream_q.push_back(8'(sy));
        if (sel <= 3) begin
            stream_q.push_back(8'($urandom_range(0, 255)));
            stream_q.push_back(8'($urandom_range(0, 255)));
            return;
        end
        bcnt = (w + 7) / 8;
        for (int i = 0; i < h * bcnt; i++) stream_q.push_back(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 4) != 0) begin
            pos = 4 + sy * bcnt + sx / 8;
            tmp = stream_q[pos];
            tmp[sx % 8] = 1'b1;
            stream_q[pos] = tmp;
        end
        x = 8'd0;
        foreach (stream_q[i]) x ^= stream_q[i];
        if (sel == 4) x ^= 8'($urandom_range(1, 255));
        stream_q.push_back(x);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int           n;
        logic [63:0]  bytes;
        logic [127:0] exp_lo;
        logic         exp_err;
        logic         exp_re;
        logic [6:0]   exp_w, exp_h, exp_cx, exp_cy;
    } vec_t;

    vec_t vecs[5];

    task automatic load_vec(input int i);
        stream_q.delete();
        for (int j = 0; j < vecs[i].n; j++) stream_q.push_back(vecs[i].bytes[8 * j +: 8]);
    endtask

    task automatic check_outputs_zero(input string name);
        check_path({name, "_path"}, '0);
        check({name, "_dims"}, {maze_width, maze_height, char_x, char_y}, 0);
        check({name, "_flags"}, {in_ready, busy, done, error, render_enable}, 0);
    endtask

    localparam logic [127:0] BITS_2X2 = (128'd1 << 64) | 128'd3;

    initial begin
        vecs[0] = '{7, 64'h0002_0103_0000_0202, BITS_2X2,     1'b0, 1'b1, 7'd2,  7'd2, 7'd0, 7'd0};
        vecs[1] = '{7, 64'h0002_FFFF_0009_010A, 128'h3FF,     1'b0, 1'b1, 7'd10, 7'd1, 7'd9, 7'd0};
        vecs[2] = '{7, 64'h0000_0103_0000_0202, BITS_2X2,     1'b1, 1'b0, 7'd2,  7'd2, 7'd0, 7'd0};
        vecs[3] = '{7, 64'h0002_0103_0101_0202, BITS_2X2,     1'b1, 1'b0, 7'd2,  7'd2, 7'd1, 7'd1};
        vecs[4] = '{1, 64'h0000_0000_0000_0041, 128'h0,       1'b1, 1'b0, 7'd2,  7'd2, 7'd1, 7'd1};

        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        check_outputs_zero("reset");
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            load_vec(i);
            model_load();
            run_load(1'b0, 1'b0);
            check("tbl_latency", lat, vecs[i].n);
            check("tbl_error", error, vecs[i].exp_err);
            check("tbl_render_enable", render_enable, vecs[i].exp_re);
            check("tbl_dims", {maze_width, maze_height, char_x, char_y},
                  {vecs[i].exp_w, vecs[i].exp_h, vecs[i].exp_cx, vecs[i].exp_cy});
            check("tbl_path_lo", path_data[63:0], vecs[i].exp_lo[63:0]);
            check("tbl_path_mid", path_data[127:64], vecs[i].exp_lo[127:64]);
            check("tbl_path_hi_zero", (path_data[4095:128] == '0) ? 1 : 0, 1);
            check_vs_model("tbl");
            if (i == 4) begin
                in_valid = 1'b1;
                in_data  = 8'h02;
                for (int c = 0; c < 2; c++) begin
                    check("hdr_err_no_accept", in_ready, 0);
                    @(posedge clk); #1;
                end
                check("hdr_err_stays_idle", {busy, done, error}, 3'b001);
                in_valid = 1'b0;
            end
        end

        // 2x2 with alternate-cycle gaps and a start pulse during the rows
        load_vec(0);
        model_load();
        run_load(1'b1, 1'b1);
        check("bp_error", error, 0);
        check("bp_render_enable", render_enable, 1);
        check_vs_model("bp");

        // reset after three header bytes aborts with no done pulse
        load_vec(0);
        begin
            int d0;
            d0    = done_cnt;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int j = 0; j < 3; j++) begin
                in_valid = 1'b1;
                in_data  = stream_q[j];
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            #2 reset = 1'b0;
            #1;
            check_outputs_zero("abort");
            repeat (2) @(posedge clk);
            #1;
            check("abort_no_done", done_cnt - d0, 0);
            @(negedge clk) reset = 1'b1;
            @(posedge clk); #1;
        end
        m_w = 0; m_h = 0; m_cx = 0; m_cy = 0;

        for (int i = 0; i < 16; i++) begin
            gen_load(i == 0);
            model_load();
            run_load(1'($urandom_range(0, 1)), 1'b0);
            check_vs_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
